issue_select: RTL and testbench
===============================

ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 SHALL use parameters from sys_defs: `N, default 2, issue width / lane count; `RS_SZ, default 8, RS entry count.
REQ-002 SHALL have port clock, input, 1, single clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port RS_data, input, RS_PACKET [`RS_SZ], RS contents incl. b_mask, Source1_ready, Source2_ready.
REQ-005 SHALL have port rs_valid, input, [`RS_SZ], entry-valid vector from RS.
REQ-006 SHALL have port fu_ready, input, [`N], per-lane downstream accept this cycle.
REQ-007 SHALL have port b_mm_resolve, input, B_MASK_MASK, resolving branch bit (one-hot or zero).
REQ-008 SHALL have port b_mm_mispred, input, 1, resolve is a mispredict.
REQ-009 SHALL have port rs_data_issuing, output, [`RS_SZ], combinational; entries RS frees at next edge.
REQ-010 SHALL have port issue_packets, output, RS_PACKET [`N], registered lane contents.
REQ-011 SHALL have port issue_valid, output, [`N], registered lane valid.

Function
REQ-012 SHALL treat entry i as eligible iff rs_valid[i] & Source1_ready & Source2_ready & !(b_mm_mispred & |(b_mask & b_mm_resolve)).
REQ-013 SHALL treat lane k as free iff !issue_valid[k] | fu_ready[k]; free_cnt = count of free lanes.
REQ-014 SHALL select min(free_cnt, eligible count) entries per cycle, assert their rs_data_issuing bits, leave all others 0.
REQ-015 SHALL assign selected entries to free lanes in ascending lane order, in priority-search order.
REQ-016 SHALL latch selected packets at next edge with issue_valid=1: one-cycle select-to-lane latency.
REQ-017 SHALL hold a lane's packet and valid unchanged (except b_mask/squash rules) while issue_valid=1 and fu_ready=0.
REQ-018 SHALL clear issue_valid[k] at next edge when fu_ready[k]=1 and no new packet assigned to lane k.
REQ-019 SHALL, on b_mm_mispred, invalidate at next edge any held lane whose b_mask & b_mm_resolve is nonzero, including stalled lanes.
REQ-020 SHALL, on resolve without mispred, clear b_mm_resolve bits in b_mask of held lanes and of newly latched packets.
REQ-021 SHALL never assert rs_data_issuing for an invalid or non-eligible entry, nor more than `N bits.
REQ-022 SHALL assert zero rs_data_issuing when all lanes are stalled (free_cnt=0), even with eligible entries.
REQ-023 SHALL ignore fu_ready on lanes with issue_valid=0.

Reset
REQ-024 SHALL, while reset=1 at an edge, set issue_valid to 0, issue_packets to 0, priority pointer to 0.
REQ-025 SHALL force rs_data_issuing to 0 during any cycle reset=1, including mid-stall or mid-squash.

Configuration
REQ-026 SHALL, with ISSUE_SELECT_RR_EN defined, search from register rr_ptr upward, wrapping at `RS_SZ-1 to 0.
REQ-027 SHALL, with ISSUE_SELECT_RR_EN defined, update rr_ptr to (last selected index + 1) mod `RS_SZ when ≥1 selected; otherwise hold.
REQ-028 SHALL, without ISSUE_SELECT_RR_EN, use fixed priority lowest index first and instantiate no pointer state.

Verification (N=2, RS_SZ=8)
REQ-029 SHALL cover: entries 1,3,6 eligible, lanes empty, RR off -> rs_data_issuing=0x0A; next cycle lane0=entry1, lane1=entry3.
REQ-030 SHALL cover: lane0 valid, fu_ready=2'b00, lane1 empty, entries 2,5 eligible -> rs_data_issuing=0x04; lane0 held, lane1=entry2.
REQ-031 SHALL cover: both lanes stalled, b_mask=0x2 and 0x4, mispred with b_mm_resolve=0x2 -> next cycle issue_valid=2'b10, lane1 b_mask=0x4.
REQ-032 SHALL cover: eligible entry b_mask=0x1, mispred with resolve=0x1 -> not selected, rs_data_issuing bit 0.
REQ-033 SHALL cover: RR on, rr_ptr=6, entries 0,7 eligible -> selects 7 then 0 (lane0=7, lane1=0); rr_ptr becomes 1.
REQ-034 SHALL cover: reset asserted with both lanes stalled -> issue_valid=0, rs_data_issuing=0 that cycle and next.

Source files
------------

// File: rtl/issue_select.sv
`default_nettype none
//==============================================================================
// Module   : issue_select
// Brief    : Picks ready RS entries into `N registered issue lanes with branch
//            squash; define ISSUE_SELECT_RR_EN for a round-robin search pointer.
// Revision : 1.0 - initial release
//==============================================================================

`ifndef N
`define N 2
`endif
`ifndef RS_SZ
`define RS_SZ 8
`endif
`ifndef B_MASK_W
`define B_MASK_W 4
`endif

`ifndef ISSUE_SELECT_TYPES_DEFINED
`define ISSUE_SELECT_TYPES_DEFINED
typedef logic [`B_MASK_W-1:0] B_MASK_MASK;
typedef struct packed {
  logic [7:0] opcode;
  logic [5:0] dest_tag;
  B_MASK_MASK b_mask;
  logic       Source1_ready;
  logic       Source2_ready;
} RS_PACKET;
`endif

module issue_select (
  input  logic              clock,
  input  logic              reset,
  input  RS_PACKET          RS_data [`RS_SZ],
  input  logic [`RS_SZ-1:0] rs_valid,
  input  logic [`N-1:0]     fu_ready,
  input  B_MASK_MASK        b_mm_resolve,
  input  logic              b_mm_mispred,
  output logic [`RS_SZ-1:0] rs_data_issuing,
  output RS_PACKET          issue_packets [`N],
  output logic [`N-1:0]     issue_valid
);

  localparam int c_N     = `N;
  localparam int c_RS_SZ = `RS_SZ;
  localparam int c_PW    = (c_RS_SZ > 1) ? $clog2(c_RS_SZ) : 1;

  logic [c_RS_SZ-1:0] w_eligible;
  logic [c_N-1:0]     w_lane_free;
  logic [c_N-1:0]     w_lane_take;
  logic [c_PW-1:0]    w_lane_sel [c_N];
  logic [c_RS_SZ-1:0] w_taken;
  logic               w_found;
  logic [c_PW:0]      w_sum;
  logic [c_PW-1:0]    w_idx;
  logic [c_PW-1:0]    w_base;

  RS_PACKET           r_issue_packets [c_N];
  logic [c_N-1:0]     r_issue_valid;

  // An entry whose branch is being mispredicted this cycle must not issue.
  for (genvar i = 0; i < c_RS_SZ; i++) begin : g_elig
    assign w_eligible[i] = rs_valid[i] & RS_data[i].Source1_ready & RS_data[i].Source2_ready
                         & ~(b_mm_mispred & (|(RS_data[i].b_mask & b_mm_resolve)));
  end

  assign w_lane_free = ~r_issue_valid | fu_ready;

`ifdef ISSUE_SELECT_RR_EN
  logic [c_PW-1:0] r_rr_ptr;
  logic [c_PW-1:0] w_last_sel;

  assign w_base = r_rr_ptr;

  always_comb begin
    w_last_sel = r_rr_ptr;
    for (int k = 0; k < c_N; k++) begin
      if (w_lane_take[k]) w_last_sel = w_lane_sel[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (|w_lane_take) begin
      r_rr_ptr <= (w_last_sel == c_PW'(c_RS_SZ - 1)) ? '0 : w_last_sel + 1'b1;
    end
  end
`else
  assign w_base = '0;
`endif

  // Free lanes are filled in ascending order, each taking the next unclaimed
  // eligible entry in search order starting at w_base.
  always_comb begin
    w_taken     = '0;
    w_lane_take = '0;
    w_found     = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < c_N; k++) w_lane_sel[k] = '0;
    for (int k = 0; k < c_N; k++) begin
      w_found = 1'b0;
      for (int j = 0; j < c_RS_SZ; j++) begin
        w_sum = (c_PW+1)'(w_base) + (c_PW+1)'(j);
        w_idx = c_PW'((w_sum >= (c_PW+1)'(c_RS_SZ)) ? (w_sum - (c_PW+1)'(c_RS_SZ)) : w_sum);
        if (w_lane_free[k] && !w_found && w_eligible[w_idx] && !w_taken[w_idx]) begin
          w_found        = 1'b1;
          w_taken[w_idx] = 1'b1;
          w_lane_take[k] = 1'b1;
          w_lane_sel[k]  = w_idx;
        end
      end
    end
  end

  assign rs_data_issuing = reset ? '0 : w_taken;

  always_ff @(posedge clock) begin
    for (int k = 0; k < c_N; k++) begin
      if (reset) begin
        r_issue_valid[k]   <= 1'b0;
        r_issue_packets[k] <= '0;
      end else if (w_lane_take[k]) begin
        r_issue_valid[k]   <= 1'b1;
        r_issue_packets[k] <= RS_data[w_lane_sel[k]];
        if (!b_mm_mispred) begin
          r_issue_packets[k].b_mask <= RS_data[w_lane_sel[k]].b_mask & ~b_mm_resolve;
        end
      end else if (r_issue_valid[k] && !fu_ready[k]) begin
        // Stalled lane: squash on a matching mispredict, else drop resolved bits.
        if (b_mm_mispred && (|(r_issue_packets[k].b_mask & b_mm_resolve))) begin
          r_issue_valid[k] <= 1'b0;
        end else if (!b_mm_mispred) begin
          r_issue_packets[k].b_mask <= r_issue_packets[k].b_mask & ~b_mm_resolve;
        end
      end else begin
        r_issue_valid[k] <= 1'b0;
      end
    end
  end

  assign issue_packets = r_issue_packets;
  assign issue_valid   = r_issue_valid;

endmodule

`default_nettype wire

// File: tb/tb_issue_select.sv
`default_nettype none
//==============================================================================
// Module   : tb_issue_select
// Brief    : Directed self-checking bench for issue_select (N=2, RS_SZ=8).
// Revision : 1.0 - initial release
//==============================================================================

`ifndef B_MASK_W
`define B_MASK_W 4
`endif

`ifndef ISSUE_SELECT_TYPES_DEFINED
`define ISSUE_SELECT_TYPES_DEFINED
typedef logic [`B_MASK_W-1:0] B_MASK_MASK;
typedef struct packed {
  logic [7:0] opcode;
  logic [5:0] dest_tag;
  B_MASK_MASK b_mask;
  logic       Source1_ready;
  logic       Source2_ready;
} RS_PACKET;
`endif

module tb_issue_select;

  logic       clock;
  logic       reset;
  RS_PACKET   rs_data [8];
  logic [7:0] rs_valid;
  logic [1:0] fu_ready;
  B_MASK_MASK b_mm_resolve;
  logic       b_mm_mispred;
  logic [7:0] rs_data_issuing;
  RS_PACKET   issue_packets [2];
  logic [1:0] issue_valid;

  int checks = 0;
  int errors = 0;

  issue_select dut (
    .clock           (clock),
    .reset           (reset),
    .RS_data         (rs_data),
    .rs_valid        (rs_valid),
    .fu_ready        (fu_ready),
    .b_mm_resolve    (b_mm_resolve),
    .b_mm_mispred    (b_mm_mispred),
    .rs_data_issuing (rs_data_issuing),
    .issue_packets   (issue_packets),
    .issue_valid     (issue_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic RS_PACKET mk(input logic [7:0] op, input logic [3:0] m,
                                  input logic r1, input logic r2);
    RS_PACKET p;
    p = '0;
    p.opcode        = op;
    p.dest_tag      = op[5:0];
    p.b_mask        = m;
    p.Source1_ready = r1;
    p.Source2_ready = r2;
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 8; i++) rs_data[i] = '0;
    rs_valid     = '0;
    fu_ready     = '0;
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    rs_data[0] = mk(8'h10, 4'h0, 1, 1);
    rs_data[1] = mk(8'h11, 4'h0, 1, 1);
    rs_valid = 8'h03;
    #1;
    checks++; if (rs_data_issuing !== 8'h00) begin errors++; $display("FAIL reset_issuing got %h want 00", rs_data_issuing); end
    tick();
    checks++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", issue_valid); end
    checks++; if (issue_packets[0] !== '0) begin errors++; $display("FAIL reset_pkt0 got %h want 0", issue_packets[0]); end
    checks++; if (issue_packets[1] !== '0) begin errors++; $display("FAIL reset_pkt1 got %h want 0", issue_packets[1]); end
    reset = 1'b0;
    #1;
    checks++; if (rs_data_issuing !== 8'h03) begin errors++; $display("FAIL post_reset_issuing got %h want 03", rs_data_issuing); end
  endtask

  task automatic test_basic();
    do_reset();
    rs_data[1] = mk(8'hA1, 4'h0, 1, 1);
    rs_data[2] = mk(8'hA2, 4'h0, 1, 0);
    rs_data[3] = mk(8'hA3, 4'h0, 1, 1);
    rs_data[4] = mk(8'hA4, 4'h0, 1, 1);
    rs_data[6] = mk(8'hA6, 4'h0, 1, 1);
    rs_valid = 8'h4E;
    #1;
    checks++; if (rs_data_issuing !== 8'h0A) begin errors++; $display("FAIL basic_issuing got %h want 0a", rs_data_issuing); end
    tick();
    checks++; if (issue_valid !== 2'b11) begin errors++; $display("FAIL basic_valid got %b want 11", issue_valid); end
    checks++; if (issue_packets[0].opcode !== 8'hA1) begin errors++; $display("FAIL basic_lane0 got %h want a1", issue_packets[0].opcode); end
    checks++; if (issue_packets[1].opcode !== 8'hA3) begin errors++; $display("FAIL basic_lane1 got %h want a3", issue_packets[1].opcode); end
    rs_valid = 8'h00;
    fu_ready = 2'b11;
    tick();
    checks++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL drain_valid got %b want 00", issue_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) rs_data[i] = mk(8'hB0 + 8'(i), 4'h0, 1, 1);
    rs_valid = 8'h0F;
    fu_ready = 2'b11;
    #1;
    checks++; if (rs_data_issuing !== 8'h03) begin errors++; $display("FAIL b2b_first got %h want 03", rs_data_issuing); end
    tick();
    rs_valid = 8'h0C;
    #1;
    checks++; if (rs_data_issuing !== 8'h0C) begin errors++; $display("FAIL b2b_second got %h want 0c", rs_data_issuing); end
    tick();
    checks++; if (issue_valid !== 2'b11) begin errors++; $display("FAIL b2b_valid got %b want 11", issue_valid); end
    checks++; if (issue_packets[0].opcode !== 8'hB2) begin errors++; $display("FAIL b2b_lane0 got %h want b2", issue_packets[0].opcode); end
    checks++; if (issue_packets[1].opcode !== 8'hB3) begin errors++; $display("FAIL b2b_lane1 got %h want b3", issue_packets[1].opcode); end
  endtask

  task automatic test_stall();
    do_reset();
    rs_data[0] = mk(8'hC0, 4'h0, 1, 1);
    rs_valid = 8'h01;
    tick();
    rs_data[2] = mk(8'hC2, 4'h0, 1, 1);
    rs_data[5] = mk(8'hC5, 4'h0, 1, 1);
    rs_valid = 8'h24;
    #1;
    checks++; if (rs_data_issuing !== 8'h04) begin errors++; $display("FAIL stall1_issuing got %h want 04", rs_data_issuing); end
    tick();
    checks++; if (issue_valid !== 2'b11) begin errors++; $display("FAIL stall1_valid got %b want 11", issue_valid); end
    checks++; if (issue_packets[0].opcode !== 8'hC0) begin errors++; $display("FAIL stall1_lane0_held got %h want c0", issue_packets[0].opcode); end
    checks++; if (issue_packets[1].opcode !== 8'hC2) begin errors++; $display("FAIL stall1_lane1 got %h want c2", issue_packets[1].opcode); end
    rs_valid = 8'h20;
    #1;
    checks++; if (rs_data_issuing !== 8'h00) begin errors++; $display("FAIL stall2_issuing got %h want 00", rs_data_issuing); end
    tick();
    checks++; if (issue_valid !== 2'b11) begin errors++; $display("FAIL stall2_valid got %b want 11", issue_valid); end
    checks++; if (issue_packets[1].opcode !== 8'hC2) begin errors++; $display("FAIL stall2_lane1_held got %h want c2", issue_packets[1].opcode); end
  endtask

  task automatic test_squash_resolve();
    do_reset();
    rs_data[0] = mk(8'hD0, 4'h2, 1, 1);
    rs_data[1] = mk(8'hD1, 4'h4, 1, 1);
    rs_valid = 8'h03;
    tick();
    rs_valid     = 8'h00;
    b_mm_mispred = 1'b1;
    b_mm_resolve = 4'h2;
    tick();
    checks++; if (issue_valid !== 2'b10) begin errors++; $display("FAIL squash_valid got %b want 10", issue_valid); end
    checks++; if (issue_packets[1].b_mask !== 4'h4) begin errors++; $display("FAIL squash_lane1_mask got %h want 4", issue_packets[1].b_mask); end
    b_mm_mispred = 1'b0;
    b_mm_resolve = 4'h4;
    rs_data[2] = mk(8'hD2, 4'h5, 1, 1);
    rs_valid = 8'h04;
    #1;
    checks++; if (rs_data_issuing !== 8'h04) begin errors++; $display("FAIL resolve_issuing got %h want 04", rs_data_issuing); end
    tick();
    checks++; if (issue_valid !== 2'b11) begin errors++; $display("FAIL resolve_valid got %b want 11", issue_valid); end
    checks++; if (issue_packets[0].b_mask !== 4'h1) begin errors++; $display("FAIL resolve_new_mask got %h want 1", issue_packets[0].b_mask); end
    checks++; if (issue_packets[1].b_mask !== 4'h0) begin errors++; $display("FAIL resolve_held_mask got %h want 0", issue_packets[1].b_mask); end
  endtask

  task automatic test_mispred_eligible();
    do_reset();
    rs_data[0] = mk(8'hE0, 4'h1, 1, 1);
    rs_data[4] = mk(8'hE4, 4'h0, 1, 1);
    rs_valid     = 8'h11;
    b_mm_mispred = 1'b1;
    b_mm_resolve = 4'h1;
    #1;
    checks++; if (rs_data_issuing !== 8'h10) begin errors++; $display("FAIL mispred_issuing got %h want 10", rs_data_issuing); end
    tick();
    checks++; if (issue_valid !== 2'b01) begin errors++; $display("FAIL mispred_valid got %b want 01", issue_valid); end
    checks++; if (issue_packets[0].opcode !== 8'hE4) begin errors++; $display("FAIL mispred_lane0 got %h want e4", issue_packets[0].opcode); end
  endtask

  task automatic test_priority();
    logic [7:0] exp_l0;
    logic [7:0] exp_l1;
    logic [7:0] exp_iss;
    logic [7:0] exp_g;
`ifdef ISSUE_SELECT_RR_EN
    exp_l0 = 8'hF7; exp_l1 = 8'hF0; exp_iss = 8'h04; exp_g = 8'h62;
`else
    exp_l0 = 8'hF0; exp_l1 = 8'hF7; exp_iss = 8'h01; exp_g = 8'h60;
`endif
    do_reset();
    rs_data[5] = mk(8'hF5, 4'h0, 1, 1);
    rs_valid = 8'h20;
    fu_ready = 2'b11;
    tick();
    rs_valid = 8'h00;
    tick();
    rs_data[0] = mk(8'hF0, 4'h0, 1, 1);
    rs_data[7] = mk(8'hF7, 4'h0, 1, 1);
    rs_valid = 8'h81;
    #1;
    checks++; if (rs_data_issuing !== 8'h81) begin errors++; $display("FAIL prio_issuing got %h want 81", rs_data_issuing); end
    tick();
    checks++; if (issue_packets[0].opcode !== exp_l0) begin errors++; $display("FAIL prio_lane0 got %h want %h", issue_packets[0].opcode, exp_l0); end
    checks++; if (issue_packets[1].opcode !== exp_l1) begin errors++; $display("FAIL prio_lane1 got %h want %h", issue_packets[1].opcode, exp_l1); end
    rs_data[0] = mk(8'h60, 4'h0, 1, 1);
    rs_data[2] = mk(8'h62, 4'h0, 1, 1);
    rs_valid = 8'h05;
    fu_ready = 2'b01;
    #1;
    checks++; if (rs_data_issuing !== exp_iss) begin errors++; $display("FAIL ptr_issuing got %h want %h", rs_data_issuing, exp_iss); end
    tick();
    checks++; if (issue_packets[0].opcode !== exp_g) begin errors++; $display("FAIL ptr_lane0 got %h want %h", issue_packets[0].opcode, exp_g); end
    checks++; if (issue_valid !== 2'b11) begin errors++; $display("FAIL ptr_valid got %b want 11", issue_valid); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    rs_data[0] = mk(8'h70, 4'h1, 1, 1);
    rs_data[1] = mk(8'h71, 4'h1, 1, 1);
    rs_valid = 8'h03;
    tick();
    rs_data[2] = mk(8'h72, 4'h0, 1, 1);
    rs_data[3] = mk(8'h73, 4'h0, 1, 1);
    rs_valid     = 8'h0C;
    b_mm_mispred = 1'b1;
    b_mm_resolve = 4'h1;
    reset        = 1'b1;
    #1;
    checks++; if (rs_data_issuing !== 8'h00) begin errors++; $display("FAIL rst_stall_issuing0 got %h want 00", rs_data_issuing); end
    tick();
    checks++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL rst_stall_valid0 got %b want 00", issue_valid); end
    checks++; if (rs_data_issuing !== 8'h00) begin errors++; $display("FAIL rst_stall_issuing1 got %h want 00", rs_data_issuing); end
    tick();
    checks++; if (issue_valid !== 2'b00) begin errors++; $display("FAIL rst_stall_valid1 got %b want 00", issue_valid); end
    reset = 1'b0;
    #1;
    checks++; if (rs_data_issuing !== 8'h0C) begin errors++; $display("FAIL rst_release_issuing got %h want 0c", rs_data_issuing); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick();
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_squash_resolve();
    test_mispred_eligible();
    test_priority();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
